booth_mult_arbiter: RTL

Round-robin arbiter and sequencer that shares one 8x8 Booth multiplier among four requesters. It latches the winning requester's operands and drives the multiplier's Start/A/B inputs. It holds Start through the multiplier's Done/clear cycle, then returns the 16-bit product to the owner with a one-cycle done pulse. It sits between client logic and the multiplier; nothing else drives the multiplier.

---
 rtl/booth_mult_arbiter_if.sv | 28 ++
 rtl/booth_mult_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/booth_mult_arbiter_if.sv
// Client/multiplier signal bundle for booth_mult_arbiter.
//   Client side : Req_Sig/Req_A/Req_B in; Grant/Done_Sig/Result/Busy out.
//   Mult side   : Mul_Start_Sig/Mul_A/Mul_B out; Mul_Done_Sig/Mul_Product in.
// slave  = arbiter view, master = view of whoever drives requests and models the multiplier.
interface booth_mult_arbiter_if;
   logic [3:0]  Req_Sig;
   logic [31:0] Req_A;
   logic [31:0] Req_B;
   logic [3:0]  Grant;
   logic [3:0]  Done_Sig;
   logic [15:0] Result;
   logic        Busy;
   logic        Mul_Start_Sig;
   logic [7:0]  Mul_A;
   logic [7:0]  Mul_B;
   logic        Mul_Done_Sig;
   logic [15:0] Mul_Product;

   modport slave (
      input  Req_Sig, Req_A, Req_B, Mul_Done_Sig, Mul_Product,
      output Grant, Done_Sig, Result, Busy, Mul_Start_Sig, Mul_A, Mul_B
   );

   modport master (
      output Req_Sig, Req_A, Req_B, Mul_Done_Sig, Mul_Product,
      input  Grant, Done_Sig, Result, Busy, Mul_Start_Sig, Mul_A, Mul_B
   );
endinterface

// File: rtl/booth_mult_arbiter.sv
// Shares one 8x8 Booth multiplier among four requesters. Arbitrates in IDLE (round-robin or
// fixed priority), latches the winner's operands, holds Start through the multiplier's done
// cycle, then returns the 16-bit product with a one-cycle Done_Sig pulse to the owner.
// Ports:
//   CLK   - clock, rising edge
//   RSTn  - asynchronous active-low reset
//   bus   - booth_mult_arbiter_if.slave (requests, grant/done/result, multiplier handshake)
module booth_mult_arbiter #(
   parameter bit PRIO_MODE = 1'b0  // 0: round-robin, 1: fixed priority (index 0 highest)
) (
   input logic                 CLK,
   input logic                 RSTn,
   booth_mult_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   state_e      r_state, w_state_nxt;
   logic [1:0]  r_ptr, w_ptr_nxt;
   logic [3:0]  r_grant, w_grant_nxt;
   logic [3:0]  r_done, w_done_nxt;
   logic [15:0] r_result, w_result_nxt;
   logic        r_start, w_start_nxt;
   logic [7:0]  r_mul_a, w_mul_a_nxt;
   logic [7:0]  r_mul_b, w_mul_b_nxt;

   logic        w_found;
   logic [1:0]  w_win;

   // Winner select. Loops run high-to-low so the last hit (highest precedence) wins.
   always_comb begin
      w_found = 1'b0;
      w_win   = 2'd0;
      if (PRIO_MODE) begin
         for (int i = 3; i >= 0; i--) begin
            if (bus.Req_Sig[i[1:0]]) begin
               w_found = 1'b1;
               w_win   = i[1:0];
            end
         end
      end else begin
         // Offsets 4..1 from ptr; offset 4 wraps back to ptr itself, searched last.
         for (int off = 4; off >= 1; off--) begin
            if (bus.Req_Sig[r_ptr + off[1:0]]) begin
               w_found = 1'b1;
               w_win   = r_ptr + off[1:0];
            end
         end
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_ptr_nxt    = r_ptr;
      w_grant_nxt  = r_grant;
      w_done_nxt   = r_done;
      w_result_nxt = r_result;
      w_start_nxt  = r_start;
      w_mul_a_nxt  = r_mul_a;
      w_mul_b_nxt  = r_mul_b;
      case (r_state)
         StIdle: begin
            if (w_found) begin
               w_ptr_nxt   = w_win;
               w_grant_nxt = 4'b0001 << w_win;
               w_mul_a_nxt = bus.Req_A[{w_win, 3'b000} +: 8];
               w_mul_b_nxt = bus.Req_B[{w_win, 3'b000} +: 8];
               w_start_nxt = 1'b1;
               w_state_nxt = StRun;
            end
         end
         StRun: begin
            // Start drops one edge after Done is sampled, so the multiplier still sees
            // Start high on its done edge and clears its step counter.
            if (bus.Mul_Done_Sig) begin
               w_start_nxt  = 1'b0;
               w_result_nxt = bus.Mul_Product;
               w_done_nxt   = r_grant;
               w_state_nxt  = StDone;
            end
         end
         StDone: begin
            w_done_nxt  = 4'b0000;
            w_grant_nxt = 4'b0000;
            w_state_nxt = StIdle;
         end
         default: begin
            w_done_nxt  = 4'b0000;
            w_grant_nxt = 4'b0000;
            w_start_nxt = 1'b0;
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_state  <= StIdle;
         r_ptr    <= 2'd3;  // requester 0 wins first after reset
         r_grant  <= 4'b0000;
         r_done   <= 4'b0000;
         r_result <= 16'h0000;
         r_start  <= 1'b0;
         r_mul_a  <= 8'h00;
         r_mul_b  <= 8'h00;
      end else begin
         r_state  <= w_state_nxt;
         r_ptr    <= w_ptr_nxt;
         r_grant  <= w_grant_nxt;
         r_done   <= w_done_nxt;
         r_result <= w_result_nxt;
         r_start  <= w_start_nxt;
         r_mul_a  <= w_mul_a_nxt;
         r_mul_b  <= w_mul_b_nxt;
      end
   end

   assign bus.Grant         = r_grant;
   assign bus.Done_Sig      = r_done;
   assign bus.Result        = r_result;
   assign bus.Busy          = (r_state != StIdle);
   assign bus.Mul_Start_Sig = r_start;
   assign bus.Mul_A         = r_mul_a;
   assign bus.Mul_B         = r_mul_b;

endmodule
